ncl_ring_sync: RTL and testbench
================================

NCL_RING_SYNC -- requirements
Module: ncl_ring_sync

Interface
REQ-001 The block SHALL have the following parameters:
- WIDTH, default 2: dual-rail bits per stage, minimum 1.
- DEPTH, default 4: number of ring stages, minimum 3.
- INIT_DATA, default 0: WIDTH-bit value of the initial DATA token.
- INVERT_STAGE, default 0: index of the stage that swaps rails, i.e. logically inverts the token.

REQ-002 The block SHALL have the following ports:
- clk  in  1  the only clock; all state updates on its rising edge.
- init  in  1  reset, synchronous and active-high.
- halt  in  1  when high, stage 0 holds its state.
- inj_valid  in  1  fault-injection strobe.
- inj_mask  in  2*WIDTH  rails OR-ed into stage 0's next value when inj_valid is high.
- stage_rails  out  DEPTH*2*WIDTH  registered state of all stages; stage i occupies bits [i*2*WIDTH +: 2*WIDTH].
- tap_valid  out  1  one-cycle pulse on each NULL->DATA transition of stage DEPTH-1.
- tap_data  out  WIDTH  logical token value of stage DEPTH-1, valid while tap_valid is high.
- wave_count  out  16  number of DATA wavefronts seen at stage DEPTH-1.
- illegal  out  1  sticky flag: some bit holds both rails high.

REQ-003 Rail encoding SHALL be the same for every bit j of a stage:
- rails [2j+1:2j] = 00 is NULL, 01 is logic 0, 10 is logic 1, 11 is illegal.

Function
REQ-010 Stage i SHALL be DATA-complete when every bit is 01 or 10, and NULL when every rail is 0. Otherwise it is partial.
REQ-011 Upstream of stage i SHALL be stage (i-1) mod DEPTH; downstream SHALL be stage (i+1) mod DEPTH.
REQ-012 Every cycle, all stages SHALL update simultaneously from previous-cycle values, according to the state of their upstream and downstream stages:
- Downstream not DATA-complete and upstream DATA-complete: load f(upstream).
- Downstream DATA-complete and upstream NULL: load NULL.
- Otherwise: hold.
REQ-013 f SHALL swap rails of every bit for stage INVERT_STAGE and be identity for all other stages.
REQ-014 While halt=1, stage 0 SHALL hold. Other stages SHALL follow REQ-012, so the ring drains and stalls.
REQ-015 When halt is deasserted, circulation SHALL resume with no token lost or duplicated.
REQ-016 inj_valid=1 SHALL OR inj_mask into the value stage 0 loads or holds that cycle. This takes effect even when halt=1.
REQ-017 tap_valid SHALL be registered, high for exactly the cycle after stage DEPTH-1 goes from not-DATA-complete to DATA-complete. tap_data SHALL equal the rail-1 bits of stage DEPTH-1 in that cycle.
REQ-018 wave_count SHALL increment by 1 with each tap_valid pulse and wrap from 16'hFFFF to 0.
REQ-019 With DEPTH=4 and halt=0, stage DEPTH-1 SHALL complete a NULL->DATA transition every 4 cycles, the first on the 4th edge after init falls.

Reset
REQ-030 With init=1 at a clock edge, the following SHALL hold after that edge:
- Stage DEPTH-1 holds the DATA encoding of INIT_DATA.
- All other stages are NULL.
- tap_valid=0, tap_data=0, wave_count=0, illegal=0.
REQ-031 init SHALL take priority over halt and inj_valid.
REQ-032 init asserted mid-operation SHALL discard every wavefront in flight; no partial state may survive.

Configuration
REQ-040 The macro NCL_RING_ILLEGAL_CHK_EN SHALL select illegal-rail checking.
REQ-041 When NCL_RING_ILLEGAL_CHK_EN is defined, checking SHALL be enabled:
- illegal is set on the cycle after any stage holds a 11 bit, and clears only on init.
- While illegal=1, all stages hold.
- tap_valid stays 0 and wave_count is frozen.
REQ-042 When NCL_RING_ILLEGAL_CHK_EN is undefined, checking SHALL be disabled:
- illegal is tied to 0.
- No freeze occurs.
- 11 bits count as neither DATA nor NULL under REQ-010.

Verification
REQ-050 Defaults, init for 1 cycle, then 12 cycles idle -> tap_valid pulses after edges 4, 8 and 12; tap_data = 2'b11, 2'b00, 2'b11; wave_count = 3.
REQ-051 halt=1 for 10 cycles mid-run -> stage_rails constant after drain; tap_valid 0 throughout; after halt=0 the tap_data sequence continues alternating with no repeat or skip.
REQ-052 init pulsed while a DATA wavefront sits in stage 1 -> stage_rails = stage 3 = 0101, others 0 on the next cycle; wave_count = 0.
REQ-053 With the macro, inj_valid=1 and inj_mask=4'b0011 for one cycle -> illegal=1 within 2 cycles; stage_rails frozen; wave_count unchanged until init.
REQ-054 Without the macro, the same injection -> illegal stays 0; the ring stalls on the partial/illegal stage and does not crash the bench.
REQ-055 WIDTH=4, DEPTH=6, INIT_DATA=4'hA, INVERT_STAGE=3 -> first tap_data = 4'h5, next 4'hA; wave_count wraps to 0 after 65536 pulses (forced preload allowed).

Source files
------------

// File: rtl/ncl_ring_sync.sv
// ncl_ring_sync: clocked model of a dual-rail NULL Convention Logic ring.
// DEPTH stages of WIDTH dual-rail bits pass a single DATA/NULL wavefront
// around the ring; stage INVERT_STAGE swaps rails so the token alternates
// each lap. Stage DEPTH-1 is tapped for wavefront arrival and counting.
// Optional macro NCL_RING_ILLEGAL_CHK_EN: sticky detection of 11 rail
// pairs, which then freezes the ring until init.

// Next-state logic for one ring stage (purely combinational).
module ncl_ring_lane #(
    parameter int WIDTH = 2,
    parameter bit INV   = 1'b0,
    parameter bit HEAD  = 1'b0
) (
    input  logic [2*WIDTH-1:0] cur,
    input  logic [2*WIDTH-1:0] up,
    input  logic               up_dc,
    input  logic               up_null,
    input  logic               dn_dc,
    input  logic               halt,
    input  logic               freeze,
    input  logic               inj_valid,
    input  logic [2*WIDTH-1:0] inj_mask,
    output logic [2*WIDTH-1:0] nxt,
    output logic               dc,
    output logic               nul
);
    logic [2*WIDTH-1:0] up_f;

    // Completion of this stage: every bit exactly one rail high / all rails low
    always_comb begin
        dc  = 1'b1;
        for (int j = 0; j < WIDTH; j++)
            dc = dc & (cur[2*j] ^ cur[2*j+1]);
        nul = ~|cur;
    end

    // Upstream value as seen by this stage: rails swapped on the inverting stage
    always_comb begin
        up_f = up;
        if (INV) begin
            for (int j = 0; j < WIDTH; j++) begin
                up_f[2*j]   = up[2*j+1];
                up_f[2*j+1] = up[2*j];
            end
        end
    end

    // Handshake rule; the head stage can be halted and takes injected rails
    always_comb begin
        nxt = cur;
        if (!(freeze || (HEAD && halt))) begin
            if (!dn_dc && up_dc)
                nxt = up_f;
            else if (dn_dc && up_null)
                nxt = '0;
        end
        if (HEAD && inj_valid)
            nxt = nxt | inj_mask;
    end
endmodule

module ncl_ring_sync #(
    parameter int               WIDTH        = 2,
    parameter int               DEPTH        = 4,
    parameter logic [WIDTH-1:0] INIT_DATA    = '0,
    parameter int               INVERT_STAGE = 0
) (
    input  logic                     clk,
    input  logic                     init,
    input  logic                     halt,
    input  logic                     inj_valid,
    input  logic [2*WIDTH-1:0]       inj_mask,
    output logic [DEPTH*2*WIDTH-1:0] stage_rails,
    output logic                     tap_valid,
    output logic [WIDTH-1:0]         tap_data,
    output logic [15:0]              wave_count,
    output logic                     illegal
);
    function automatic logic [2*WIDTH-1:0] enc(input logic [WIDTH-1:0] d);
        logic [2*WIDTH-1:0] r;
        for (int j = 0; j < WIDTH; j++)
            r[2*j +: 2] = d[j] ? 2'b10 : 2'b01;
        return r;
    endfunction

    localparam logic [2*WIDTH-1:0] INIT_RAILS = enc(INIT_DATA);
    localparam logic [DEPTH-1:0][2*WIDTH-1:0] RST_RAILS =
        {INIT_RAILS, {((DEPTH-1)*2*WIDTH){1'b0}}};

    logic [DEPTH-1:0][2*WIDTH-1:0] rails_q;
    logic [DEPTH-1:0][2*WIDTH-1:0] nxt_all;
    logic [DEPTH-1:0]              dc_all;
    logic [DEPTH-1:0]              nul_all;
    logic                          freeze;
    logic                          last_nxt_dc;
    logic [WIDTH-1:0]              last_bits;
    logic                          rise;
    logic [15:0]                   wave_q;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_stage
            localparam int UP = (i + DEPTH - 1) % DEPTH;
            localparam int DN = (i + 1) % DEPTH;
            ncl_ring_lane #(
                .WIDTH (WIDTH),
                .INV   (i == INVERT_STAGE),
                .HEAD  (i == 0)
            ) u_lane (
                .cur       (rails_q[i]),
                .up        (rails_q[UP]),
                .up_dc     (dc_all[UP]),
                .up_null   (nul_all[UP]),
                .dn_dc     (dc_all[DN]),
                .halt      (halt),
                .freeze    (freeze),
                .inj_valid (inj_valid),
                .inj_mask  (inj_mask),
                .nxt       (nxt_all[i]),
                .dc        (dc_all[i]),
                .nul       (nul_all[i])
            );
        end
    endgenerate

`ifdef NCL_RING_ILLEGAL_CHK_EN
    logic illegal_q;
    logic any_ill;

    // Any 11 rail pair anywhere in the ring
    always_comb begin
        any_ill = 1'b0;
        for (int s = 0; s < DEPTH; s++)
            for (int j = 0; j < WIDTH; j++)
                any_ill = any_ill | (&rails_q[s][2*j +: 2]);
    end

    // Sticky illegal flag, cleared only by init
    always_ff @(posedge clk) begin
        if (init)
            illegal_q <= 1'b0;
        else if (any_ill)
            illegal_q <= 1'b1;
    end

    assign freeze  = illegal_q;
    assign illegal = illegal_q;
`else
    assign freeze  = 1'b0;
    assign illegal = 1'b0;
`endif

    // Completion and logical value of the tap stage's next state
    always_comb begin
        last_nxt_dc = 1'b1;
        for (int j = 0; j < WIDTH; j++) begin
            last_nxt_dc  = last_nxt_dc & (nxt_all[DEPTH-1][2*j] ^ nxt_all[DEPTH-1][2*j+1]);
            last_bits[j] = nxt_all[DEPTH-1][2*j+1];
        end
    end

    assign rise = !freeze && !dc_all[DEPTH-1] && last_nxt_dc;

    // All stages update together; init drops every wavefront in flight
    always_ff @(posedge clk) begin
        if (init)
            rails_q <= RST_RAILS;
        else
            rails_q <= nxt_all;
    end

    // Tap pulse, captured token and wavefront counter
    always_ff @(posedge clk) begin
        if (init) begin
            tap_valid <= 1'b0;
            tap_data  <= '0;
            wave_q    <= '0;
        end else begin
            tap_valid <= rise;
            if (rise) begin
                tap_data <= last_bits;
                wave_q   <= wave_q + 16'd1;
            end
        end
    end

    assign stage_rails = rails_q;
    assign wave_count  = wave_q;
endmodule

// File: tb/tb_ncl_ring_sync.sv
// Bench for ncl_ring_sync: default 4x2 ring plus a 6x4 ring with inversion
// at stage 3. Tap tokens are checked against scoreboard queues.
module tb_ncl_ring_sync;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        init, halt, inj_valid;
    logic [3:0]  inj_mask;
    logic [15:0] rails_a;
    logic        tv_a;
    logic [1:0]  td_a;
    logic [15:0] wave_a;
    logic        ill_a;

    logic        init_b, halt_b, inj_valid_b;
    logic [7:0]  inj_mask_b;
    logic [47:0] rails_b;
    logic        tv_b;
    logic [3:0]  td_b;
    logic [15:0] wave_b;
    logic        ill_b;

    ncl_ring_sync dut_a (
        .clk(clk), .init(init), .halt(halt), .inj_valid(inj_valid), .inj_mask(inj_mask),
        .stage_rails(rails_a), .tap_valid(tv_a), .tap_data(td_a), .wave_count(wave_a),
        .illegal(ill_a)
    );

    ncl_ring_sync #(.WIDTH(4), .DEPTH(6), .INIT_DATA(4'hA), .INVERT_STAGE(3)) dut_b (
        .clk(clk), .init(init_b), .halt(halt_b), .inj_valid(inj_valid_b), .inj_mask(inj_mask_b),
        .stage_rails(rails_b), .tap_valid(tv_b), .tap_data(td_b), .wave_count(wave_b),
        .illegal(ill_b)
    );

    int         total = 0;
    int         bad   = 0;
    logic [1:0] qa[$];
    logic [3:0] qb[$];
    bit         sb_a  = 1'b0;
    int         npb   = 0;
    logic [1:0] ea;
    logic [3:0] eb;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard for ring A tap tokens
    initial forever begin
        @(negedge clk);
        if (sb_a && tv_a) begin
            total++;
            if (qa.size() == 0) begin
                bad++;
                $error("FAIL sb_a_unexpected got=%0h exp=none", td_a);
            end else begin
                ea = qa.pop_front();
                assert (td_a === ea) else begin
                    bad++;
                    $error("FAIL sb_a_data got=%0h exp=%0h", td_a, ea);
                end
            end
        end
    end

    // Scoreboard for ring B tap tokens
    initial forever begin
        @(negedge clk);
        if (tv_b) begin
            npb++;
            total++;
            if (qb.size() == 0) begin
                bad++;
                $error("FAIL sb_b_unexpected got=%0h exp=none", td_b);
            end else begin
                eb = qb.pop_front();
                assert (td_b === eb) else begin
                    bad++;
                    $error("FAIL sb_b_data got=%0h exp=%0h", td_b, eb);
                end
            end
        end
    end

    logic [15:0] snap_r, snap_w;
    bit          found;
    int          n;

    initial begin
        init = 1'b1; halt = 1'b0; inj_valid = 1'b0; inj_mask = '0;
        init_b = 1'b1; halt_b = 1'b0; inj_valid_b = 1'b0; inj_mask_b = '0;

        // reset state
        tick();
        init = 1'b0;
        chk("rst_rails", rails_a, 16'h5000);
        chk("rst_tap_valid", tv_a, 0);
        chk("rst_tap_data", td_a, 0);
        chk("rst_wave", wave_a, 0);
        chk("rst_illegal", ill_a, 0);

        // free run: pulses after edges 4, 8, 12 with tokens 11, 00, 11
        sb_a = 1'b1;
        qa.push_back(2'b11); qa.push_back(2'b00); qa.push_back(2'b11);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("run_tap_valid", tv_a, (k % 4 == 0) ? 1 : 0);
            if (k == 1) chk("edge1_rails", rails_a, 16'h500A);
        end
        settle();
        chk("run_wave", wave_a, 3);
        chk("run_q_empty", qa.size(), 0);

        // halt: ring drains to a fixed pattern, no pulses
        halt = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("halt_tap_valid", tv_a, 0);
        end
        snap_r = rails_a;
        chk("halt_rails", snap_r, 16'hA000);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("halt_const", rails_a, snap_r);
            chk("halt_tap_valid", tv_a, 0);
        end
        halt = 1'b0;
        qa.push_back(2'b00); qa.push_back(2'b11);
        for (int k = 0; k < 8; k++) tick();
        settle();
        chk("resume_q_empty", qa.size(), 0);
        chk("resume_wave", wave_a, 5);

        // init while a DATA wavefront sits in stage 1
        found = 1'b0;
        n = 0;
        while (!found && n < 8) begin
            tick();
            n++;
            found = ((rails_a[4] ^ rails_a[5]) & (rails_a[6] ^ rails_a[7])) == 1'b1;
        end
        chk("s1_data_found", found, 1);
        qa.delete();
        init = 1'b1;
        tick();
        init = 1'b0;
        chk("mid_init_rails", rails_a, 16'h5000);
        chk("mid_init_wave", wave_a, 0);
        chk("mid_init_tap_valid", tv_a, 0);
        qa.push_back(2'b11); qa.push_back(2'b00);
        for (int k = 0; k < 8; k++) tick();
        settle();
        chk("post_init_q_empty", qa.size(), 0);
        chk("post_init_wave", wave_a, 2);

        // fault injection of an 11 rail pair into stage 0
        sb_a = 1'b0;
        inj_valid = 1'b1; inj_mask = 4'b0011;
        tick();
        inj_valid = 1'b0; inj_mask = '0;
        tick();
`ifdef NCL_RING_ILLEGAL_CHK_EN
        chk("inj_illegal", ill_a, 1);
        snap_r = rails_a;
        snap_w = wave_a;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("frozen_rails", rails_a, snap_r);
            chk("frozen_wave", wave_a, snap_w);
            chk("frozen_tap_valid", tv_a, 0);
        end
`else
        chk("inj_illegal", ill_a, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("inj_illegal", ill_a, 0);
        end
`endif
        init = 1'b1;
        tick();
        init = 1'b0;
        chk("reinit_illegal", ill_a, 0);
        chk("reinit_rails", rails_a, 16'h5000);

        // ring B: inverted token alternates 5, A
        qb.push_back(4'h5); qb.push_back(4'hA); qb.push_back(4'h5); qb.push_back(4'hA);
        init_b = 1'b0;
        n = 0;
        while (npb < 4 && n < 100) begin
            tick();
            n++;
        end
        settle();
        chk("b_pulses", npb, 4);
        chk("b_wave", wave_b, 4);

        // preload counter near wrap
        force dut_b.wave_q = 16'hFFFE;
        #1;
        release dut_b.wave_q;
        qb.push_back(4'h5); qb.push_back(4'hA);
        n = 0;
        while (npb < 5 && n < 100) begin
            tick();
            n++;
        end
        settle();
        chk("b_wave_ffff", wave_b, 16'hFFFF);
        while (npb < 6 && n < 200) begin
            tick();
            n++;
        end
        settle();
        chk("b_pulses_wrap", npb, 6);
        chk("b_wave_wrap", wave_b, 0);
        chk("b_q_empty", qb.size(), 0);
        chk("b_illegal", ill_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
